// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_WAIT = 2'd1,
    D_WAIT = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_DR   = 2'd2,
    GNT_DW   = 2'd3
  } arb_gnt_t;

  localparam int STREAK_W = 4;

  // Bit positions inside the picker's one-hot grant vector
  localparam int GNT_I_BIT  = 0;
  localparam int GNT_DR_BIT = 1;
  localparam int GNT_DW_BIT = 2;

  function automatic arb_gnt_t gnt_decode(input logic [2:0] oh);
    arb_gnt_t g;
    g = GNT_NONE;
    if (oh[GNT_DW_BIT])      g = GNT_DW;
    else if (oh[GNT_DR_BIT]) g = GNT_DR;
    else if (oh[GNT_I_BIT])  g = GNT_I;
    return g;
  endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Priority picker: data write > data read > instruction, with the instruction
// forced through once the data streak reaches MAX_DATA_STREAK. Also computes
// the next streak value.
module mem_arb_picker
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                i_arb_en,
  input  logic                i_i_req,
  input  logic                i_d_rd,
  input  logic                i_d_wr,
  input  logic [STREAK_W-1:0] i_streak,
  output logic [2:0]          o_gnt_oh,
  output logic [STREAK_W-1:0] o_streak_nxt
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  logic w_forced;
  logic w_data_gnt;

  assign w_forced   = i_i_req && (i_streak == STREAK_MAX);
  assign w_data_gnt = o_gnt_oh[GNT_DW_BIT] | o_gnt_oh[GNT_DR_BIT];

  // Fixed-priority selection, one grant per arbitration cycle
  always_comb begin
    o_gnt_oh = '0;
    if (i_arb_en) begin
      if (i_d_wr && !w_forced)      o_gnt_oh[GNT_DW_BIT] = 1'b1;
      else if (i_d_rd && !w_forced) o_gnt_oh[GNT_DR_BIT] = 1'b1;
      else if (i_i_req)             o_gnt_oh[GNT_I_BIT]  = 1'b1;
    end
  end

  // Streak counts data grants the waiting instruction has lost; any cycle
  // without a waiting instruction, or an instruction grant, clears it.
  always_comb begin
    o_streak_nxt = i_streak;
    if (i_arb_en) begin
      if (w_data_gnt && i_i_req) begin
        if (i_streak >= STREAK_MAX) o_streak_nxt = STREAK_MAX;
        else                        o_streak_nxt = i_streak + 1'b1;
      end else begin
        o_streak_nxt = '0;
      end
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port ssram between the instruction fetch and data ports.
// Writes complete in the grant cycle; reads take a grant cycle plus a wait
// cycle for the ssram's one-cycle read latency.
//
// state  | meaning
// IDLE   | arbitrate and issue at most one access this cycle
// I_WAIT | instruction read in flight, ssram data returns this cycle
// D_WAIT | data read in flight, ssram data returns this cycle
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W          = 10,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_en,
  input  logic [31:0]       i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_rdy,
  input  logic              d_read_en,
  input  logic              d_write_en,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_be,
  output logic [31:0]       d_rdata,
  output logic              d_read_rdy,
  output logic              d_write_rdy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic [3:0]        mem_write_byte_enable,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [31:0]       mem_read_data,
  output logic              proto_err
);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [STREAK_W-1:0] r_streak;
  logic [STREAK_W-1:0] w_streak_nxt;
  logic [31:0]         r_i_hold;
  logic [31:0]         r_d_hold;
  logic                r_proto_err;
  logic [2:0]          w_gnt_oh;
  arb_gnt_t            w_gnt;
  logic                w_arb_en;
  logic [ADDR_W-1:0]   w_i_word;
  logic [ADDR_W-1:0]   w_d_word;
  logic                w_unused;

  // Arbitration is suppressed while reset is asserted so no strobe or rdy
  // can leak out combinationally from requests held through reset.
  assign w_arb_en = rst && (r_state == IDLE);
  assign w_i_word = i_addr[ADDR_W+1:2];
  assign w_d_word = d_addr[ADDR_W+1:2];
  assign w_unused = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                      d_addr[31:ADDR_W+2], d_addr[1:0]};

  mem_arb_picker #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_picker (
    .i_arb_en    (w_arb_en),
    .i_i_req     (i_req_en),
    .i_d_rd      (d_read_en),
    .i_d_wr      (d_write_en),
    .i_streak    (r_streak),
    .o_gnt_oh    (w_gnt_oh),
    .o_streak_nxt(w_streak_nxt)
  );

  assign w_gnt     = gnt_decode(w_gnt_oh);
  assign proto_err = r_proto_err;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state, ssram strobes/muxing and port handshakes
  always_comb begin
    w_state_nxt           = r_state;
    mem_address           = '0;
    mem_write_data        = '0;
    mem_write_byte_enable = '0;
    mem_write_enable      = 1'b0;
    mem_read_enable       = 1'b0;
    i_rdy                 = 1'b0;
    d_read_rdy            = 1'b0;
    d_write_rdy           = 1'b0;
    i_rdata               = r_i_hold;
    d_rdata               = r_d_hold;
    case (r_state)
      IDLE: begin
        case (w_gnt)
          GNT_DW: begin
            mem_write_enable      = 1'b1;
            mem_address           = w_d_word;
            mem_write_data        = d_wdata;
            mem_write_byte_enable = d_be;
            d_write_rdy           = 1'b1;
          end
          GNT_DR: begin
            mem_read_enable = 1'b1;
            mem_address     = w_d_word;
            w_state_nxt     = D_WAIT;
          end
          GNT_I: begin
            mem_read_enable = 1'b1;
            mem_address     = w_i_word;
            w_state_nxt     = I_WAIT;
          end
          default: ;
        endcase
      end
      I_WAIT: begin
        i_rdy       = 1'b1;
        i_rdata     = mem_read_data;
        w_state_nxt = IDLE;
      end
      D_WAIT: begin
        d_read_rdy  = 1'b1;
        d_rdata     = mem_read_data;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Instruction anti-starvation streak counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_streak <= '0;
    else      r_streak <= w_streak_nxt;
  end

  // Hold registers keep the last returned read data visible between reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i_hold <= '0;
      r_d_hold <= '0;
    end else begin
      if (r_state == I_WAIT) r_i_hold <= mem_read_data;
      if (r_state == D_WAIT) r_d_hold <= mem_read_data;
    end
  end

  // Sticky flag for a requester driving read and write together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         r_proto_err <= 1'b0;
    else if (d_read_en && d_write_en) r_proto_err <= 1'b1;
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a behavioural ssram model.
module tb_unified_mem_arbiter;

  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic              i_req_en;
  logic [31:0]       i_addr;
  logic [31:0]       i_rdata;
  logic              i_rdy;
  logic              d_read_en;
  logic              d_write_en;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_be;
  logic [31:0]       d_rdata;
  logic              d_read_rdy;
  logic              d_write_rdy;
  logic [ADDR_W-1:0] mem_address;
  logic [31:0]       mem_write_data;
  logic [3:0]        mem_write_byte_enable;
  logic              mem_write_enable;
  logic              mem_read_enable;
  logic [31:0]       mem_read_data;
  logic              proto_err;

  int n_chk  = 0;
  int n_fail = 0;

  unified_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_DATA_STREAK(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_req_en             (i_req_en),
    .i_addr               (i_addr),
    .i_rdata              (i_rdata),
    .i_rdy                (i_rdy),
    .d_read_en            (d_read_en),
    .d_write_en           (d_write_en),
    .d_addr               (d_addr),
    .d_wdata              (d_wdata),
    .d_be                 (d_be),
    .d_rdata              (d_rdata),
    .d_read_rdy           (d_read_rdy),
    .d_write_rdy          (d_write_rdy),
    .mem_address          (mem_address),
    .mem_write_data       (mem_write_data),
    .mem_write_byte_enable(mem_write_byte_enable),
    .mem_write_enable     (mem_write_enable),
    .mem_read_enable      (mem_read_enable),
    .mem_read_data        (mem_read_data),
    .proto_err            (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ssram model: byte-enabled write, one-cycle registered read
  logic [31:0] mem_model [0:(1<<ADDR_W)-1];
  logic [31:0] m_rdata = 32'h0;
  assign mem_read_data = m_rdata;

  always @(posedge clk) begin
    if (mem_write_enable) begin
      for (int b = 0; b < 4; b++)
        if (mem_write_byte_enable[b])
          mem_model[mem_address][8*b +: 8] <= mem_write_data[8*b +: 8];
    end
    if (mem_read_enable) m_rdata <= mem_model[mem_address];
  end

  // Observed outputs as one vector: re, we, addr, wdata, be, irdy, drrdy, dwrdy, irdata, drdata, perr
  logic [115:0] obs;
  assign obs = {mem_read_enable, mem_write_enable, mem_address, mem_write_data,
                mem_write_byte_enable, i_rdy, d_read_rdy, d_write_rdy,
                i_rdata, d_rdata, proto_err};

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        e_re;
    logic        e_we;
    logic [9:0]  e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic        e_irdy;
    logic        e_drrdy;
    logic        e_dwrdy;
    logic [31:0] e_irdata;
    logic [31:0] e_drdata;
    logic        e_perr;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dw, input logic [31:0] da, input logic [31:0] dd,
                       input logic [3:0] be);
    i_req_en   = ir;
    i_addr     = ia;
    d_read_en  = dr;
    d_write_en = dw;
    d_addr     = da;
    d_wdata    = dd;
    d_be       = be;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [115:0] exp_v;
  logic [9:0]   gnt_i;
  int           n_gnt;
  int           drops;
  int           rdy_seen;

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++) mem_model[a] = 32'h0;
    mem_model[4] = 32'h00500093;

    // i_req,i_addr,d_rd,d_wr,d_addr,d_wdata,d_be | re,we,addr,wdata,be, irdy,drrdy,dwrdy, irdata,drdata,perr
    vecs[0]  = '{0, 32'h0,        0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 10'd0, 32'h0,        4'h0, 0, 0, 0, 32'h0,        32'h0,        0};
    vecs[1]  = '{1, 32'h10,       0, 0, 32'h0,    32'h0,        4'h0, 1, 0, 10'd4, 32'h0,        4'h0, 0, 0, 0, 32'h0,        32'h0,        0};
    vecs[2]  = '{1, 32'h10,       0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 10'd0, 32'h0,        4'h0, 1, 0, 0, 32'h00500093, 32'h0,        0};
    vecs[3]  = '{0, 32'h0,        0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 10'd0, 32'h0,        4'h0, 0, 0, 0, 32'h00500093, 32'h0,        0};
    vecs[4]  = '{0, 32'h0,        0, 1, 32'h20,   32'hDEADBEEF, 4'h3, 0, 1, 10'd8, 32'hDEADBEEF, 4'h3, 0, 0, 1, 32'h00500093, 32'h0,        0};
    vecs[5]  = '{0, 32'h0,        1, 0, 32'h20,   32'h0,        4'h0, 1, 0, 10'd8, 32'h0,        4'h0, 0, 0, 0, 32'h00500093, 32'h0,        0};
    vecs[6]  = '{0, 32'h0,        1, 0, 32'h20,   32'h0,        4'h0, 0, 0, 10'd0, 32'h0,        4'h0, 0, 1, 0, 32'h00500093, 32'h0000BEEF, 0};
    vecs[7]  = '{0, 32'h0,        0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 10'd0, 32'h0,        4'h0, 0, 0, 0, 32'h00500093, 32'h0000BEEF, 0};
    vecs[8]  = '{0, 32'h0,        0, 1, 32'h1003, 32'h11223344, 4'hF, 0, 1, 10'd0, 32'h11223344, 4'hF, 0, 0, 1, 32'h00500093, 32'h0000BEEF, 0};
    vecs[9]  = '{0, 32'h0,        1, 0, 32'h1003, 32'h0,        4'h0, 1, 0, 10'd0, 32'h0,        4'h0, 0, 0, 0, 32'h00500093, 32'h0000BEEF, 0};
    vecs[10] = '{0, 32'h0,        1, 0, 32'h1003, 32'h0,        4'h0, 0, 0, 10'd0, 32'h0,        4'h0, 0, 1, 0, 32'h00500093, 32'h11223344, 0};
    vecs[11] = '{1, 32'hFFFFF010, 0, 0, 32'h0,    32'h0,        4'h0, 1, 0, 10'd4, 32'h0,        4'h0, 0, 0, 0, 32'h00500093, 32'h11223344, 0};
    vecs[12] = '{0, 32'h0,        0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 10'd0, 32'h0,        4'h0, 1, 0, 0, 32'h00500093, 32'h11223344, 0};
    vecs[13] = '{1, 32'h10,       1, 0, 32'h20,   32'h0,        4'h0, 1, 0, 10'd8, 32'h0,        4'h0, 0, 0, 0, 32'h00500093, 32'h11223344, 0};
    vecs[14] = '{1, 32'h10,       0, 0, 32'h20,   32'h0,        4'h0, 0, 0, 10'd0, 32'h0,        4'h0, 0, 1, 0, 32'h00500093, 32'h0000BEEF, 0};
    vecs[15] = '{1, 32'h10,       0, 0, 32'h0,    32'h0,        4'h0, 1, 0, 10'd4, 32'h0,        4'h0, 0, 0, 0, 32'h00500093, 32'h0000BEEF, 0};
    vecs[16] = '{1, 32'h10,       0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 10'd0, 32'h0,        4'h0, 1, 0, 0, 32'h00500093, 32'h0000BEEF, 0};

    // Reset state: everything quiet, hold registers zero
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("reset_outputs", 128'(obs), 128'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Table-driven single-cycle vectors
    for (int k = 0; k < NVEC; k++) begin
      @(posedge clk);
      #1;
      drive(vecs[k].i_req, vecs[k].i_addr, vecs[k].d_rd, vecs[k].d_wr,
            vecs[k].d_addr, vecs[k].d_wdata, vecs[k].d_be);
      exp_v = {vecs[k].e_re, vecs[k].e_we, vecs[k].e_addr, vecs[k].e_wdata,
               vecs[k].e_be, vecs[k].e_irdy, vecs[k].e_drrdy, vecs[k].e_dwrdy,
               vecs[k].e_irdata, vecs[k].e_drdata, vecs[k].e_perr};
      @(negedge clk);
      chk($sformatf("vec%0d", k), 128'(obs), 128'(exp_v));
    end

    // Anti-starvation: both requests held, expect D,D,D,D,I,D,D,D,D,I
    do_reset();
    @(posedge clk);
    #1;
    drive(1, 32'h10, 1, 0, 32'h20, 0, 0);
    n_gnt = 0;
    gnt_i = '0;
    for (int c = 0; c < 60 && n_gnt < 10; c++) begin
      @(negedge clk);
      if (mem_read_enable) begin
        gnt_i[n_gnt] = (mem_address == 10'd4);
        n_gnt++;
      end
    end
    chk("starve_grant_count", 128'(n_gnt), 128'd10);
    for (int g = 0; g < 10; g++)
      chk($sformatf("starve_gnt%0d_is_instr", g), 128'(gnt_i[g]), 128'((g == 4) || (g == 9)));

    // Simultaneous read+write: write first, sticky proto_err until reset
    do_reset();
    @(posedge clk);
    #1;
    drive(0, 0, 1, 1, 32'h40, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    chk("pe_write_first", 128'({mem_write_enable, d_write_rdy, mem_read_enable, mem_address}), 128'({1'b1, 1'b1, 1'b0, 10'h10}));
    chk("pe_not_yet", 128'(proto_err), 128'd0);
    @(posedge clk);
    #1;
    d_write_en = 1'b0;
    @(negedge clk);
    chk("pe_set", 128'(proto_err), 128'd1);
    chk("pe_read_issue", 128'({mem_read_enable, mem_address}), 128'({1'b1, 10'h10}));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("pe_read_data", 128'({d_read_rdy, d_rdata}), 128'({1'b1, 32'hCAFEF00D}));
    @(posedge clk);
    #1;
    d_read_en = 1'b0;
    drops = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (proto_err !== 1'b1) drops++;
    end
    chk("pe_sticky_100", 128'(drops), 128'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("pe_cleared_by_reset", 128'(proto_err), 128'd0);
    @(negedge clk);
    rst = 1'b1;

    // Asynchronous reset in the middle of I_WAIT drops the read
    @(posedge clk);
    #1;
    drive(1, 32'h10, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("ar_issue", 128'({mem_read_enable, mem_address}), 128'({1'b1, 10'd4}));
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_outputs_zero", 128'({i_rdy, mem_read_enable, mem_address, i_rdata}), 128'h0);
    i_req_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rdy_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (i_rdy) rdy_seen++;
    end
    chk("ar_no_late_rdy", 128'(rdy_seen), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
